// File: rtl/dd_stage_n.sv
// dd_stage_n: parametrised hash distributor stage.
// Lanes are grouped in pairs (2p, 2p+1). Each pair steers every tuple into its
// own "zero" or "one" FIFO by tuple bit DECISION_BIT. When both lanes of a pair
// target the same FIFO, a per-FIFO round-robin pointer decides which lane is
// granted. Pairs are fully independent of each other.
module dd_stage_n #(
  parameter  int INPUT_SIZE   = 64,
  parameter  int DECISION_BIT = 0,
  parameter  int NUM_LANES    = 4,
  parameter  int FIFO_DEPTH   = 4,
  localparam int NUM_PAIRS    = NUM_LANES / 2,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LANES*INPUT_SIZE-1:0] in_data,
  input  logic [NUM_LANES*32-1:0]         in_tag,
  input  logic [NUM_LANES-1:0]            in_valid,
  output logic [NUM_LANES-1:0]            in_ready,
  output logic [NUM_PAIRS*INPUT_SIZE-1:0] zero_data,
  output logic [NUM_PAIRS*32-1:0]         zero_tag,
  output logic [NUM_PAIRS-1:0]            zero_valid,
  input  logic [NUM_PAIRS-1:0]            zero_ready,
  output logic [NUM_PAIRS*INPUT_SIZE-1:0] one_data,
  output logic [NUM_PAIRS*32-1:0]         one_tag,
  output logic [NUM_PAIRS-1:0]            one_valid,
  input  logic [NUM_PAIRS-1:0]            one_ready,
  output logic [NUM_PAIRS*CW-1:0]         zero_count,
  output logic [NUM_PAIRS*CW-1:0]         one_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    localparam int LA = 2 * p;
    localparam int LB = 2 * p + 1;

    // Index 0 is the zero FIFO, index 1 the one FIFO.
    logic [INPUT_SIZE-1:0]  mem_data_q [2][FIFO_DEPTH];
    logic [31:0]            mem_tag_q  [2][FIFO_DEPTH];
    logic [1:0][PW-1:0]     wr_ptr_q;
    logic [1:0][PW-1:0]     rd_ptr_q;
    logic [1:0][CW-1:0]     count_q;
    logic [1:0][CW-1:0]     count_d;
    // Priority pointer per FIFO: 0 = lane a, 1 = lane b.
    logic [1:0]             prio_q;
    logic [1:0]             prio_d;

    logic [INPUT_SIZE-1:0]  data_a_s;
    logic [INPUT_SIZE-1:0]  data_b_s;
    logic [31:0]            tag_a_s;
    logic [31:0]            tag_b_s;
    logic                   valid_a_s;
    logic                   valid_b_s;
    logic                   tgt_a_s;
    logic                   tgt_b_s;
    logic                   contend_s;
    logic                   ready_a_s;
    logic                   ready_b_s;
    logic [1:0]             not_full_s;
    logic [1:0]             push_s;
    logic [1:0]             push_from_b_s;
    logic [1:0]             pop_s;
    logic [1:0]             out_ready_s;

    assign data_a_s    = in_data[LA*INPUT_SIZE +: INPUT_SIZE];
    assign data_b_s    = in_data[LB*INPUT_SIZE +: INPUT_SIZE];
    assign tag_a_s     = in_tag[LA*32 +: 32];
    assign tag_b_s     = in_tag[LB*32 +: 32];
    assign valid_a_s   = in_valid[LA];
    assign valid_b_s   = in_valid[LB];
    assign tgt_a_s     = data_a_s[DECISION_BIT];
    assign tgt_b_s     = data_b_s[DECISION_BIT];
    assign out_ready_s = {one_ready[p], zero_ready[p]};

    // Grant logic: per-lane ready, FIFO push/pop strobes and next count/priority.
    always_comb begin
      contend_s = valid_a_s && valid_b_s && (tgt_a_s == tgt_b_s);
      ready_a_s = 1'b0;
      ready_b_s = 1'b0;
      for (int t = 0; t < 2; t++) begin
        // Full is judged on the registered count only: no same-cycle pop bypass.
        not_full_s[t] = (count_q[t] != CW'(FIFO_DEPTH));
        pop_s[t]      = (count_q[t] != {CW{1'b0}}) && out_ready_s[t];
      end
      if (reset) begin
        ready_a_s = 1'b0;
        ready_b_s = 1'b0;
      end else if (contend_s) begin
        if (prio_q[tgt_a_s]) begin
          ready_b_s = not_full_s[tgt_a_s];
        end else begin
          ready_a_s = not_full_s[tgt_a_s];
        end
      end else begin
        ready_a_s = valid_a_s && not_full_s[tgt_a_s];
        ready_b_s = valid_b_s && not_full_s[tgt_b_s];
      end
      push_s[0]        = (ready_a_s && !tgt_a_s) || (ready_b_s && !tgt_b_s);
      push_s[1]        = (ready_a_s &&  tgt_a_s) || (ready_b_s &&  tgt_b_s);
      push_from_b_s[0] = ready_b_s && !tgt_b_s;
      push_from_b_s[1] = ready_b_s &&  tgt_b_s;
      for (int t = 0; t < 2; t++) begin
        case ({push_s[t], pop_s[t]})
          2'b10:   count_d[t] = count_q[t] + CW'(1);
          2'b01:   count_d[t] = count_q[t] - CW'(1);
          default: count_d[t] = count_q[t];
        endcase
        // Only a contended transfer hands priority to the other lane.
        if (contend_s && push_s[t]) begin
          prio_d[t] = ~prio_q[t];
        end else begin
          prio_d[t] = prio_q[t];
        end
      end
    end

    // FIFO control state: pointers, occupancy and round-robin priority.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= {2*PW{1'b0}};
        rd_ptr_q <= {2*PW{1'b0}};
        count_q  <= {2*CW{1'b0}};
        prio_q   <= 2'b00;
      end else begin
        for (int t = 0; t < 2; t++) begin
          if (push_s[t]) begin
            wr_ptr_q[t] <= wr_ptr_q[t] + PW'(1);
          end
          if (pop_s[t]) begin
            rd_ptr_q[t] <= rd_ptr_q[t] + PW'(1);
          end
        end
        count_q <= count_d;
        prio_q  <= prio_d;
      end
    end

    // FIFO storage: write the granted lane's tuple and tag at the write pointer.
    always_ff @(posedge clk) begin
      for (int t = 0; t < 2; t++) begin
        if (!reset && push_s[t]) begin
          mem_data_q[t][wr_ptr_q[t]] <= push_from_b_s[t] ? data_b_s : data_a_s;
          mem_tag_q[t][wr_ptr_q[t]]  <= push_from_b_s[t] ? tag_b_s  : tag_a_s;
        end
      end
    end

    assign in_ready[LA] = ready_a_s;
    assign in_ready[LB] = ready_b_s;

    assign zero_data[p*INPUT_SIZE +: INPUT_SIZE] = mem_data_q[0][rd_ptr_q[0]];
    assign zero_tag[p*32 +: 32]                  = mem_tag_q[0][rd_ptr_q[0]];
    assign zero_valid[p]                         = (count_q[0] != {CW{1'b0}});
    assign zero_count[p*CW +: CW]                = count_q[0];

    assign one_data[p*INPUT_SIZE +: INPUT_SIZE]  = mem_data_q[1][rd_ptr_q[1]];
    assign one_tag[p*32 +: 32]                   = mem_tag_q[1][rd_ptr_q[1]];
    assign one_valid[p]                          = (count_q[1] != {CW{1'b0}});
    assign one_count[p*CW +: CW]                 = count_q[1];
  end

endmodule

// File: tb/tb_dd_stage_n.sv
// tb_dd_stage_n: randomized self-checking bench for dd_stage_n.
// Reference model: one queue per output FIFO plus a priority bit per FIFO;
// expected readiness is derived from lane valids, decision bits and queue sizes.
module tb_dd_stage_n;
  localparam int W  = 64;
  localparam int DB = 0;
  localparam int NL = 4;
  localparam int NP = NL / 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NL*W-1:0]   in_data;
  logic [NL*32-1:0]  in_tag;
  logic [NL-1:0]     in_valid;
  logic [NL-1:0]     in_ready;
  logic [NP*W-1:0]   zero_data, one_data;
  logic [NP*32-1:0]  zero_tag, one_tag;
  logic [NP-1:0]     zero_valid, one_valid, zero_ready, one_ready;
  logic [NP*CW-1:0]  zero_count, one_count;

  dd_stage_n #(.INPUT_SIZE(W), .DECISION_BIT(DB), .NUM_LANES(NL), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
    .zero_data(zero_data), .zero_tag(zero_tag), .zero_valid(zero_valid), .zero_ready(zero_ready),
    .one_data(one_data), .one_tag(one_tag), .one_valid(one_valid), .one_ready(one_ready),
    .zero_count(zero_count), .one_count(one_count)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [31:0]  t;
  } ent_t;

  ent_t        mq    [2*NP][$];   // index 2*pair + target
  bit          mprio [2*NP];      // 0 = lane a holds priority
  logic [W-1:0] ld   [NL];
  logic [31:0]  lt   [NL];
  bit           lv   [NL];
  int unsigned  tag_ctr [NL];

  int checks = 0;
  int errors = 0;
  int pv = 0;
  int pr = 0;
  int fb = -1;

  task automatic check_val(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit rst_v);
    bit er [NL];
    bit con [NP];
    int cidx [NP];
    int a, b, ta, tb, idx;
    bit ov;
    logic [W-1:0] od;
    logic [31:0] ot;
    logic [CW-1:0] oc;
    bit rdy;

    reset = rst_v;
    for (int l = 0; l < NL; l++) begin
      if (!lv[l] && ($urandom_range(99) < pv)) begin
        lv[l] = 1'b1;
        ld[l] = {$urandom, $urandom};
        if (fb >= 0) ld[l][DB] = fb[0];
        lt[l] = tag_ctr[l];
        tag_ctr[l]++;
      end
      in_valid[l]         = lv[l];
      in_data[l*W +: W]   = ld[l];
      in_tag[l*32 +: 32]  = lt[l];
    end
    for (int p = 0; p < NP; p++) begin
      zero_ready[p] = ($urandom_range(99) < pr);
      one_ready[p]  = ($urandom_range(99) < pr);
    end
    #1;

    // expected readiness from the arbitration rules
    for (int l = 0; l < NL; l++) er[l] = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a = 2 * p;
      b = 2 * p + 1;
      ta = ld[a][DB] ? 1 : 0;
      tb = ld[b][DB] ? 1 : 0;
      con[p]  = lv[a] && lv[b] && (ta == tb);
      cidx[p] = 2 * p + ta;
      if (!rst_v) begin
        if (con[p]) begin
          if (mq[cidx[p]].size() < D) begin
            if (mprio[cidx[p]]) er[b] = 1'b1;
            else er[a] = 1'b1;
          end
        end else begin
          if (lv[a] && mq[2*p+ta].size() < D) er[a] = 1'b1;
          if (lv[b] && mq[2*p+tb].size() < D) er[b] = 1'b1;
        end
      end
    end
    for (int l = 0; l < NL; l++)
      check_val($sformatf("in_ready[%0d]", l), 96'(in_ready[l]), 96'(er[l]));

    for (int p = 0; p < NP; p++) begin
      for (int t = 0; t < 2; t++) begin
        idx = 2 * p + t;
        ov = (t == 1) ? one_valid[p] : zero_valid[p];
        od = (t == 1) ? one_data[p*W +: W] : zero_data[p*W +: W];
        ot = (t == 1) ? one_tag[p*32 +: 32] : zero_tag[p*32 +: 32];
        oc = (t == 1) ? one_count[p*CW +: CW] : zero_count[p*CW +: CW];
        check_val($sformatf("valid p%0d t%0d", p, t), 96'(ov), 96'(mq[idx].size() > 0));
        check_val($sformatf("count p%0d t%0d", p, t), 96'(oc), 96'(mq[idx].size()));
        if (mq[idx].size() > 0) begin
          check_val($sformatf("data p%0d t%0d", p, t), 96'(od), 96'(mq[idx][0].d));
          check_val($sformatf("tag p%0d t%0d", p, t), 96'(ot), 96'(mq[idx][0].t));
        end
      end
    end

    @(posedge clk);
    if (rst_v) begin
      for (int i = 0; i < 2*NP; i++) begin
        mq[i].delete();
        mprio[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        for (int t = 0; t < 2; t++) begin
          idx = 2 * p + t;
          rdy = (t == 1) ? one_ready[p] : zero_ready[p];
          if (rdy && mq[idx].size() > 0) void'(mq[idx].pop_front());
        end
      end
      for (int l = 0; l < NL; l++) begin
        if (er[l]) begin
          idx = 2 * (l / 2) + (ld[l][DB] ? 1 : 0);
          mq[idx].push_back({ld[l], lt[l]});
          lv[l] = 1'b0;
        end
      end
      for (int p = 0; p < NP; p++)
        if (con[p] && (er[2*p] || er[2*p+1])) mprio[cidx[p]] = !mprio[cidx[p]];
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input int vpct, input int rpct, input int fbit);
    pv = vpct;
    pr = rpct;
    fb = fbit;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = '0;
    in_data    = '0;
    in_tag     = '0;
    zero_ready = '0;
    one_ready  = '0;
    for (int i = 0; i < 2*NP; i++) mprio[i] = 1'b0;
    for (int l = 0; l < NL; l++) begin
      lv[l]      = 1'b0;
      ld[l]      = '0;
      lt[l]      = '0;
      tag_ctr[l] = 32'(l) << 24;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state: empty FIFOs, no readiness
    pv = 0; pr = 0; fb = -1;
    step(1'b1);

    run(150, 60, 70, -1);   // mixed traffic
    run(100, 90, 20, -1);   // heavy backpressure, FIFOs fill up
    run(6, 80, 0, -1);      // buffer entries without draining
    pv = 80; pr = 50;
    step(1'b1);             // reset with entries buffered
    run(40, 100, 100, 1);   // all lanes contend on the one FIFO
    run(40, 100, 100, 0);   // all lanes contend on the zero FIFO
    run(100, 70, 90, -1);   // mostly streaming, pointer wrap-around
    run(60, 50, 50, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
